ein_rx: RTL and testbench
=========================

EIN_RX -- requirements
Module: ein_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per serial input (min 2).
REQ-002 clk  input  1  single block clock; all state on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 EMO_IN  input  1  frame enable from link; high = frame in progress; asynchronous to clk.
REQ-005 EDI_IN  input  1  serial data, LSB first, valid at ECI_IN rise; asynchronous.
REQ-006 ECI_IN  input  1  serial clock; data sampled on rising edge; asynchronous.
REQ-007 fifo_dout  output  8  received byte, registered, valid while fifo_WE high.
REQ-008 fifo_WE  output  1  one-cycle write strobe to downstream FIFO.
REQ-009 fifo_full  input  1  downstream FIFO full; write suppressed when high.
REQ-010 rx_active  output  1  high while in state RX.
REQ-011 frame_done  output  1  one-cycle pulse at end of every accepted frame.
REQ-012 frame_err  output  1  sticky: frame ended on non-byte boundary.
REQ-013 overflow  output  1  sticky: byte dropped because fifo_full.
REQ-014 clr_status  input  1  synchronous clear of frame_err and overflow.

Function
REQ-015 EMO_IN, EDI_IN, ECI_IN SHALL each pass through a SYNC_STAGES-flop synchronizer; all logic uses synchronized copies (emo_s, edi_s, eci_s).
REQ-016 One extra register per emo_s and eci_s SHALL provide rise/fall detect pulses.
REQ-017 States: IDLE, RX. IDLE -> RX only on emo_s rising edge; level-high EMO at entry to IDLE SHALL NOT start a frame.
REQ-018 In RX, each eci_s rise SHALL write edi_s into shift-register bit [bit_ctr] and increment 3-bit bit_ctr (wraps 7 -> 0).
REQ-019 On the eci_s rise with bit_ctr==7, the completed byte SHALL be registered onto fifo_dout and fifo_WE asserted for exactly one cycle on the following clk edge (SYNC_STAGES+1 edges after ECI_IN capture).
REQ-020 If fifo_full is high in that write cycle: fifo_WE stays low, byte dropped, overflow set; reception continues.
REQ-021 eci_s rises in IDLE SHALL be ignored; EDI changes without ECI rise have no effect.
REQ-022 emo_s fall in RX: transition to IDLE, pulse frame_done, bit_ctr cleared; if bit_ctr!=0 partial byte discarded and frame_err set.
REQ-023 Simultaneous emo_s fall and eci_s rise: fall wins, ECI sample discarded.
REQ-024 Simultaneous clr_status and a set condition: set wins.
REQ-025 Zero-byte frame (EMO pulse with no ECI) SHALL pulse frame_done, no write, no error.
REQ-026 Back-to-back frames SHALL be accepted provided emo_s is low for at least one synchronized cycle.

Reset
REQ-027 resetn low SHALL asynchronously force state IDLE, bit_ctr 0, shift register 0, synchronizers 0, and all outputs (fifo_dout, fifo_WE, rx_active, frame_done, frame_err, overflow) to 0.
REQ-028 Reset mid-frame discards the partial byte; after release a new EMO rise is required.

Structure
REQ-029 Shared package ein_pkg SHALL hold state encodings (IDLE, RX) and default SYNC_STAGES, alongside existing ein transmitter constants.
REQ-030 Synchronizer SHALL be sub-module ein_sync (parameter STAGES, async active-low reset), instantiated three times.
REQ-031 No combinational path from any serial input to any output.

Verification
REQ-032 Frame with byte 0xA5, ECI half-period 8 clk -> one fifo_WE, fifo_dout=0xA5, one frame_done, frame_err=0, overflow=0.
REQ-033 Frame 0x01,0x80,0xFF -> three fifo_WE in order with those values, single frame_done after EMO fall.
REQ-034 Frame 0x11,0x22,0x33 with fifo_full high across second byte -> writes 0x11,0x33 only, overflow=1 until clr_status pulse, then 0.
REQ-035 EMO falls after 5 ECI rises -> no fifo_WE, frame_done pulse, frame_err=1; next clean frame 0x5A received correctly, frame_err still 1.
REQ-036 EMO_IN high at reset release with ECI toggling -> no writes; EMO low then high, byte 0x3C -> one write 0x3C.
REQ-037 resetn low after 4 bits -> all outputs 0 immediately; next frame 0xC3 -> single write 0xC3.

Source files
------------

// File: rtl/ein_pkg.sv
// Shared constants and types for the ein serial link (receiver and transmitter).
package ein_pkg;

  // Default synchronizer depth for asynchronous link inputs.
  localparam int unsigned EIN_SYNC_STAGES_DEF = 2;

  // Byte and bit-counter widths.
  localparam int unsigned EIN_BYTE_W    = 8;
  localparam int unsigned EIN_BIT_CTR_W = 3;

  // Transmitter: default serial clock half-period in block clocks.
  localparam int unsigned EIN_TX_HALF_PERIOD_DEF = 8;

  // Receiver state encoding.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } ein_rx_state_e;

endpackage

// File: rtl/ein_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
// Ports: clk, resetn (async active-low), d (async input), q (synchronized output).
module ein_sync
  import ein_pkg::*;
#(
  parameter int unsigned STAGES = EIN_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ein_rx.sv
// ein serial link receiver: synchronizes EMO/EDI/ECI, deserializes LSB-first
// bytes and writes them to a downstream FIFO, with frame status reporting.
// Ports:
//   clk, resetn        block clock, async active-low reset
//   EMO_IN/EDI_IN/ECI_IN  asynchronous frame enable, serial data, serial clock
//   fifo_dout/fifo_WE  received byte and one-cycle write strobe
//   fifo_full          downstream full; blocks the write
//   rx_active          frame in progress
//   frame_done         one-cycle pulse at frame end
//   frame_err/overflow sticky status, cleared by clr_status
module ein_rx
  import ein_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = EIN_SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  EMO_IN,
  input  logic                  EDI_IN,
  input  logic                  ECI_IN,
  output logic [EIN_BYTE_W-1:0] fifo_dout,
  output logic                  fifo_WE,
  input  logic                  fifo_full,
  output logic                  rx_active,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  clr_status
);

  localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);

  logic emo_s;
  logic edi_s;
  logic eci_s;

  ein_sync #(.STAGES(SYNC_STAGES)) u_sync_emo (
    .clk(clk), .resetn(resetn), .d(EMO_IN), .q(emo_s)
  );
  ein_sync #(.STAGES(SYNC_STAGES)) u_sync_edi (
    .clk(clk), .resetn(resetn), .d(EDI_IN), .q(edi_s)
  );
  ein_sync #(.STAGES(SYNC_STAGES)) u_sync_eci (
    .clk(clk), .resetn(resetn), .d(ECI_IN), .q(eci_s)
  );

  ein_rx_state_e             state_q,      state_d;
  logic [EIN_BIT_CTR_W-1:0]  bit_ctr_q,    bit_ctr_d;
  logic [EIN_BYTE_W-1:0]     shift_q,      shift_d;
  logic [EIN_BYTE_W-1:0]     fifo_dout_q,  fifo_dout_d;
  logic                      fifo_we_q,    fifo_we_d;
  logic                      rx_active_q,  rx_active_d;
  logic                      frame_done_q, frame_done_d;
  logic                      frame_err_q,  frame_err_d;
  logic                      overflow_q,   overflow_d;
  logic                      emo_prev_q,   emo_prev_d;
  logic                      eci_prev_q,   eci_prev_d;
  logic [SETTLE_W-1:0]       settle_q,     settle_d;
  logic                      armed_q,      armed_d;

  logic emo_rise;
  logic emo_fall;
  logic eci_rise;

  assign emo_rise = emo_s & ~emo_prev_q;
  assign emo_fall = ~emo_s & emo_prev_q;
  assign eci_rise = eci_s & ~eci_prev_q;

  // Next-state, datapath and status logic.
  // armed_q blocks frame start until emo_s has been seen low once the
  // synchronizer has flushed after reset, so an EMO already high at reset
  // release is not mistaken for a rising edge.
  always_comb begin
    state_d      = state_q;
    bit_ctr_d    = bit_ctr_q;
    shift_d      = shift_q;
    fifo_dout_d  = fifo_dout_q;
    fifo_we_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    overflow_d   = overflow_q;
    emo_prev_d   = emo_s;
    eci_prev_d   = eci_s;
    settle_d     = settle_q;
    armed_d      = armed_q;

    // Clear first so any set below takes priority.
    if (clr_status) begin
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
    end

    if (settle_q != SETTLE_W'(SYNC_STAGES)) begin
      settle_d = settle_q + SETTLE_W'(1);
    end else if (!emo_s) begin
      armed_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (emo_rise && armed_q) begin
          state_d   = ST_RX;
          bit_ctr_d = '0;
          shift_d   = '0;
        end
      end
      ST_RX: begin
        // Frame end wins over a coincident serial clock edge.
        if (emo_fall) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          bit_ctr_d    = '0;
          if (bit_ctr_q != '0) begin
            frame_err_d = 1'b1;
          end
        end else if (eci_rise) begin
          shift_d[bit_ctr_q] = edi_s;
          bit_ctr_d          = bit_ctr_q + EIN_BIT_CTR_W'(1);
          if (bit_ctr_q == EIN_BIT_CTR_W'(7)) begin
            if (fifo_full) begin
              overflow_d = 1'b1;
            end else begin
              fifo_we_d   = 1'b1;
              fifo_dout_d = {edi_s, shift_q[6:0]};
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_active_d = (state_d == ST_RX);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      bit_ctr_q    <= '0;
      shift_q      <= '0;
      fifo_dout_q  <= '0;
      fifo_we_q    <= 1'b0;
      rx_active_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      emo_prev_q   <= 1'b0;
      eci_prev_q   <= 1'b0;
      settle_q     <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_ctr_q    <= bit_ctr_d;
      shift_q      <= shift_d;
      fifo_dout_q  <= fifo_dout_d;
      fifo_we_q    <= fifo_we_d;
      rx_active_q  <= rx_active_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      emo_prev_q   <= emo_prev_d;
      eci_prev_q   <= eci_prev_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
    end
  end

  assign fifo_dout  = fifo_dout_q;
  assign fifo_WE    = fifo_we_q;
  assign rx_active  = rx_active_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ein_rx.sv
// Testbench for ein_rx: table of single-byte frames plus hand-written
// multi-byte, overflow, error and reset sequences; bytes checked via scoreboard.
module tb_ein_rx;
  import ein_pkg::*;

  localparam int H = int'(EIN_TX_HALF_PERIOD_DEF);

  logic       clk        = 1'b0;
  logic       resetn     = 1'b0;
  logic       EMO_IN     = 1'b0;
  logic       EDI_IN     = 1'b0;
  logic       ECI_IN     = 1'b0;
  logic       fifo_full  = 1'b0;
  logic       clr_status = 1'b0;
  logic [7:0] fifo_dout;
  logic       fifo_WE;
  logic       rx_active;
  logic       frame_done;
  logic       frame_err;
  logic       overflow;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int wr_cnt      = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  ein_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .EMO_IN    (EMO_IN),
    .EDI_IN    (EDI_IN),
    .ECI_IN    (ECI_IN),
    .fifo_dout (fifo_dout),
    .fifo_WE   (fifo_WE),
    .fifo_full (fifo_full),
    .rx_active (rx_active),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clr_status(clr_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (fifo_WE) begin
      check("write_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_b = sb.pop_front();
        check("fifo_dout", 32'(fifo_dout), 32'(exp_b));
      end
      wr_cnt++;
    end
    if (frame_done) done_cnt++;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      EDI_IN = b[i];
      clks(H);
      ECI_IN = 1'b1;
      clks(H);
      ECI_IN = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_wr);
    if (expect_wr) sb.push_back(b);
    send_bits(b, 8);
  endtask

  task automatic frame_start();
    EMO_IN = 1'b1;
    clks(H);
  endtask

  task automatic frame_end();
    clks(H);
    EMO_IN = 1'b0;
    clks(8);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    clks(1);
    clr_status = 1'b0;
    clks(1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       full;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[5];
  int   d0;
  int   w0;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b0, 1'b0};
    tbl[4] = '{8'h81, 1'b1, 1'b1};

    // Reset state
    clks(3);
    check("rst_fifo_dout",  32'(fifo_dout),  32'd0);
    check("rst_fifo_WE",    32'(fifo_WE),    32'd0);
    check("rst_rx_active",  32'(rx_active),  32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
    resetn = 1'b1;
    clks(6);

    // Single-byte frames from the table
    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      w0 = wr_cnt;
      fifo_full = tbl[i].full;
      frame_start();
      check("rx_active_in_frame", 32'(rx_active), 32'd1);
      send_byte(tbl[i].data, !tbl[i].full);
      frame_end();
      fifo_full = 1'b0;
      check("tbl_done_count", 32'(done_cnt - d0), 32'd1);
      check("tbl_write_count", 32'(wr_cnt - w0), tbl[i].full ? 32'd0 : 32'd1);
      check("tbl_overflow", 32'(overflow), 32'(tbl[i].exp_ovf));
      check("tbl_frame_err", 32'(frame_err), 32'd0);
      check("tbl_rx_active_after", 32'(rx_active), 32'd0);
      check("tbl_sb_empty", 32'(sb.size()), 32'd0);
      pulse_clr();
      check("tbl_overflow_cleared", 32'(overflow), 32'd0);
    end

    // Three-byte frame, single frame_done only after EMO falls
    d0 = done_cnt;
    w0 = wr_cnt;
    frame_start();
    send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'hFF, 1'b1);
    clks(H);
    check("multi_no_done_before_fall", 32'(done_cnt - d0), 32'd0);
    frame_end();
    check("multi_done_count", 32'(done_cnt - d0), 32'd1);
    check("multi_write_count", 32'(wr_cnt - w0), 32'd3);
    check("multi_sb_empty", 32'(sb.size()), 32'd0);

    // Full across the middle byte: dropped, overflow sticky until cleared
    w0 = wr_cnt;
    frame_start();
    send_byte(8'h11, 1'b1);
    fifo_full = 1'b1;
    send_byte(8'h22, 1'b0);
    fifo_full = 1'b0;
    send_byte(8'h33, 1'b1);
    frame_end();
    check("ovf_write_count", 32'(wr_cnt - w0), 32'd2);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_no_frame_err", 32'(frame_err), 32'd0);
    clks(20);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_clr();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Zero-byte frame
    d0 = done_cnt;
    w0 = wr_cnt;
    EMO_IN = 1'b1;
    clks(10);
    EMO_IN = 1'b0;
    clks(8);
    check("zero_done_count", 32'(done_cnt - d0), 32'd1);
    check("zero_write_count", 32'(wr_cnt - w0), 32'd0);
    check("zero_frame_err", 32'(frame_err), 32'd0);

    // Partial frame (5 bits) then a clean frame; frame_err stays sticky
    d0 = done_cnt;
    w0 = wr_cnt;
    frame_start();
    send_bits(8'h1F, 5);
    frame_end();
    check("part_write_count", 32'(wr_cnt - w0), 32'd0);
    check("part_done_count", 32'(done_cnt - d0), 32'd1);
    check("part_frame_err", 32'(frame_err), 32'd1);
    frame_start();
    send_byte(8'h5A, 1'b1);
    frame_end();
    check("part_next_write", 32'(wr_cnt - w0), 32'd1);
    check("part_err_sticky", 32'(frame_err), 32'd1);

    // Reset after 4 bits: outputs drop immediately; next frame clean
    frame_start();
    send_bits(8'hC3, 4);
    resetn = 1'b0;
    #1;
    check("mid_rst_fifo_dout",  32'(fifo_dout),  32'd0);
    check("mid_rst_fifo_WE",    32'(fifo_WE),    32'd0);
    check("mid_rst_rx_active",  32'(rx_active),  32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_frame_err",  32'(frame_err),  32'd0);
    check("mid_rst_overflow",   32'(overflow),   32'd0);
    EMO_IN = 1'b0;
    clks(2);
    resetn = 1'b1;
    clks(6);
    w0 = wr_cnt;
    frame_start();
    send_byte(8'hC3, 1'b1);
    frame_end();
    check("post_rst_write_count", 32'(wr_cnt - w0), 32'd1);
    check("post_rst_frame_err", 32'(frame_err), 32'd0);

    // EMO already high at reset release: ECI activity must be ignored
    resetn = 1'b0;
    EMO_IN = 1'b1;
    clks(2);
    resetn = 1'b1;
    d0 = done_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      EDI_IN = 1'($urandom_range(0, 1));
      clks(H / 2);
      ECI_IN = ~ECI_IN;
      clks(H / 2);
    end
    ECI_IN = 1'b0;
    clks(4);
    check("lvl_write_count", 32'(wr_cnt - w0), 32'd0);
    check("lvl_rx_active", 32'(rx_active), 32'd0);
    check("lvl_done_count", 32'(done_cnt - d0), 32'd0);
    EMO_IN = 1'b0;
    clks(6);
    frame_start();
    send_byte(8'h3C, 1'b1);
    frame_end();
    check("lvl_next_write", 32'(wr_cnt - w0), 32'd1);
    check("lvl_next_done", 32'(done_cnt - d0), 32'd1);

    clks(10);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
